// File: rtl/input_p4_vswitch_demux.sv
// Ingress demux: steers each whole AXI4-Stream packet to one of the virtual P4 switches
// by its 802.1Q VID, with per-switch packet counters, a drop counter and a forward pulse.
module input_p4_vswitch_demux #(
    parameter int NUM_QUEUES           = 3,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 304,
    parameter int DEFAULT_SWITCH       = 0,
    parameter int DROP_UNMAPPED        = 1,
    parameter int CNT_WIDTH            = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
    output logic                              m_axis_0_tvalid,
    input  logic                              m_axis_0_tready,
    output logic                              m_axis_0_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
    output logic                              m_axis_1_tvalid,
    input  logic                              m_axis_1_tready,
    output logic                              m_axis_1_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_2_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_2_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_2_tuser,
    output logic                              m_axis_2_tvalid,
    input  logic                              m_axis_2_tready,
    output logic                              m_axis_2_tlast,

    output logic [CNT_WIDTH-1:0]              pkt_cnt_0,
    output logic [CNT_WIDTH-1:0]              pkt_cnt_1,
    output logic [CNT_WIDTH-1:0]              pkt_cnt_2,
    output logic [CNT_WIDTH-1:0]              drop_cnt,
    output logic                              pkt_in
);

    localparam int NUM_PORTS = 3;
    localparam int SEL_W     = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SWITCH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q [NUM_PORTS];
    logic [CNT_WIDTH-1:0]   pkt_cnt_d [NUM_PORTS];
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
    logic                   pkt_in_q, pkt_in_d;

    logic [15:0]            ethertype;
    logic [11:0]            vid;
    logic                   dec_tagged;
    logic                   dec_in_range;
    logic                   dec_drop;
    logic [SEL_W-1:0]       dec_sel;

    logic [SEL_W-1:0]       route_sel;
    logic                   route_drop;
    logic [NUM_PORTS-1:0]   route_oh;
    logic [NUM_PORTS-1:0]   m_tready;
    logic [NUM_PORTS-1:0]   m_tvalid;
    logic                   s_ready;
    logic                   handshake;
    logic                   first_beat;

    // Header decode; only consulted while IDLE, so later beats never re-route a packet.
    assign ethertype    = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
    assign vid          = {s_axis_tdata[115:112], s_axis_tdata[127:120]};
    assign dec_tagged   = (ethertype == 16'h8100);
    assign dec_in_range = (vid < 12'(NUM_QUEUES));
    assign dec_drop     = dec_tagged && !dec_in_range && (DROP_UNMAPPED != 0);

    always_comb begin
        dec_sel = DEF_SEL;
        if (dec_tagged && dec_in_range) begin
            dec_sel = vid[SEL_W-1:0];
        end
    end

    assign m_tready   = {m_axis_2_tready, m_axis_1_tready, m_axis_0_tready};
    assign route_sel  = (state_q == S_IDLE) ? dec_sel : sel_q;
    assign route_drop = (state_q == S_IDLE) ? dec_drop : (state_q == S_DROP);

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_route
            assign route_oh[gi] = (gi < NUM_QUEUES) && (route_sel == SEL_W'(gi));
        end
    endgenerate

    // State register
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (handshake && !s_axis_tlast) begin
                    sel_d   = dec_sel;
                    state_d = dec_drop ? S_DROP : S_FWD;
                end
            end
            S_FWD, S_DROP: begin
                if (handshake && s_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; everything is held quiet while reset is asserted.
    always_comb begin
        m_tvalid = '0;
        s_ready  = 1'b0;
        if (axis_resetn) begin
            if (route_drop) begin
                s_ready = 1'b1;
            end else begin
                m_tvalid = route_oh & {NUM_PORTS{s_axis_tvalid}};
                s_ready  = |(route_oh & m_tready);
            end
        end
    end

    assign handshake  = s_axis_tvalid && s_ready;
    assign first_beat = handshake && (state_q == S_IDLE);

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
            always_comb begin
                pkt_cnt_d[gi] = pkt_cnt_q[gi];
                if (first_beat && !dec_drop && route_oh[gi]) begin
                    pkt_cnt_d[gi] = pkt_cnt_q[gi] + CNT_WIDTH'(1);
                end
            end

            always_ff @(posedge axis_aclk or negedge axis_resetn) begin
                if (!axis_resetn) begin
                    pkt_cnt_q[gi] <= '0;
                end else begin
                    pkt_cnt_q[gi] <= pkt_cnt_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (first_beat && dec_drop) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
        pkt_in_d = first_beat && !dec_drop;
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            drop_cnt_q <= '0;
            pkt_in_q   <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            pkt_in_q   <= pkt_in_d;
        end
    end

    assign s_axis_tready = s_ready;

    // Data path is a zero-latency broadcast; only tvalid is steered.
    assign m_axis_0_tdata  = s_axis_tdata;
    assign m_axis_0_tkeep  = s_axis_tkeep;
    assign m_axis_0_tuser  = s_axis_tuser;
    assign m_axis_0_tlast  = s_axis_tlast;
    assign m_axis_0_tvalid = m_tvalid[0];

    assign m_axis_1_tdata  = s_axis_tdata;
    assign m_axis_1_tkeep  = s_axis_tkeep;
    assign m_axis_1_tuser  = s_axis_tuser;
    assign m_axis_1_tlast  = s_axis_tlast;
    assign m_axis_1_tvalid = m_tvalid[1];

    assign m_axis_2_tdata  = s_axis_tdata;
    assign m_axis_2_tkeep  = s_axis_tkeep;
    assign m_axis_2_tuser  = s_axis_tuser;
    assign m_axis_2_tlast  = s_axis_tlast;
    assign m_axis_2_tvalid = m_tvalid[2];

    assign pkt_cnt_0 = pkt_cnt_q[0];
    assign pkt_cnt_1 = pkt_cnt_q[1];
    assign pkt_cnt_2 = pkt_cnt_q[2];
    assign drop_cnt  = drop_cnt_q;
    assign pkt_in    = pkt_in_q;

endmodule

// File: tb/tb_input_p4_vswitch_demux.sv
// Directed bench for input_p4_vswitch_demux: two instances (DROP_UNMAPPED = 1 and 0)
// share one input stream; delivered beats and counters are scored against a small model.
module tb_input_p4_vswitch_demux;

    localparam int DW = 256;
    localparam int UW = 304;
    localparam int KW = DW / 8;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid;
    logic          s_tlast;
    logic [2:0]    base_rdy;
    logic          tog_rdy;
    logic          bp_mode;
    wire  [2:0]    m_rdy = {base_rdy[2], bp_mode ? tog_rdy : base_rdy[1], base_rdy[0]};

    wire          s_tready [2];
    wire [DW-1:0] m_tdata  [2][3];
    wire [KW-1:0] m_tkeep  [2][3];
    wire [UW-1:0] m_tuser  [2][3];
    wire          m_tvalid [2][3];
    wire          m_tlast  [2][3];
    wire [CW-1:0] pkt_cnt  [2][3];
    wire [CW-1:0] drop_cnt [2];
    wire          pkt_in   [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            input_p4_vswitch_demux #(
                .NUM_QUEUES(3), .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW),
                .DEFAULT_SWITCH(0), .DROP_UNMAPPED((gi == 0) ? 1 : 0), .CNT_WIDTH(CW)
            ) u_dut (
                .axis_aclk(clk), .axis_resetn(rstn),
                .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
                .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready[gi]), .s_axis_tlast(s_tlast),
                .m_axis_0_tdata(m_tdata[gi][0]), .m_axis_0_tkeep(m_tkeep[gi][0]),
                .m_axis_0_tuser(m_tuser[gi][0]), .m_axis_0_tvalid(m_tvalid[gi][0]),
                .m_axis_0_tready(m_rdy[0]), .m_axis_0_tlast(m_tlast[gi][0]),
                .m_axis_1_tdata(m_tdata[gi][1]), .m_axis_1_tkeep(m_tkeep[gi][1]),
                .m_axis_1_tuser(m_tuser[gi][1]), .m_axis_1_tvalid(m_tvalid[gi][1]),
                .m_axis_1_tready(m_rdy[1]), .m_axis_1_tlast(m_tlast[gi][1]),
                .m_axis_2_tdata(m_tdata[gi][2]), .m_axis_2_tkeep(m_tkeep[gi][2]),
                .m_axis_2_tuser(m_tuser[gi][2]), .m_axis_2_tvalid(m_tvalid[gi][2]),
                .m_axis_2_tready(m_rdy[2]), .m_axis_2_tlast(m_tlast[gi][2]),
                .pkt_cnt_0(pkt_cnt[gi][0]), .pkt_cnt_1(pkt_cnt[gi][1]),
                .pkt_cnt_2(pkt_cnt[gi][2]), .drop_cnt(drop_cnt[gi]), .pkt_in(pkt_in[gi])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observed side (written only by the monitor); queue index = inst*3 + master
    logic [DW-1:0] got_q [6][$];
    int            vcnt [6];
    int            pin_cnt [2];

    // Expected side (written only by the stimulus)
    logic [DW-1:0] exp_q [6][$];
    int            pos [6];
    int            cnt_exp [2][3];
    int            drop_exp [2];
    int            pin_exp [2];
    int            pin_base [2];

    initial begin
        for (int k = 0; k < 6; k++) vcnt[k] = 0;
        for (int i = 0; i < 2; i++) pin_cnt[i] = 0;
    end

    // Sample on the falling edge: a valid&&ready seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                int nv;
                nv = 0;
                for (int q = 0; q < 3; q++) begin
                    if (m_tvalid[i][q]) begin
                        nv++;
                        vcnt[i*3+q]++;
                        if (m_rdy[q]) got_q[i*3+q].push_back(m_tdata[i][q]);
                    end
                end
                if (nv != 0) chk("onehot_tvalid", DW'(nv), DW'(1));
                if (pkt_in[i]) pin_cnt[i]++;
            end
            if (bp_mode && s_tvalid) chk("bp_mirror", DW'(s_tready[0]), DW'(m_rdy[1]));
        end
    end

    function automatic int dest_of(input int inst, input logic [15:0] eth, input logic [11:0] vid);
        if (eth == 16'h8100) begin
            if (vid < 12'd3) return int'(vid);
            return (inst == 0) ? 3 : 0;
        end
        return 0;
    endfunction

    function automatic logic [DW-1:0] hdr(input logic [15:0] eth, input logic [11:0] vid,
                                          input logic [7:0] id);
        logic [DW-1:0] h;
        h = {(DW/32){24'hC0FFEE, id}};
        h[103:96]  = eth[15:8];
        h[111:104] = eth[7:0];
        h[115:112] = vid[11:8];
        h[119:116] = 4'h5;
        h[127:120] = vid[7:0];
        return h;
    endfunction

    function automatic logic [DW-1:0] body(input logic [7:0] id, input int b);
        return {(DW/32){16'hBEEF, id, 8'(b)}};
    endfunction

    // Presents n_send beats of an n_total-beat packet; tvalid stays high on return.
    task automatic send_pkt(input logic [15:0] eth, input logic [11:0] vid, input int n_total,
                            input int n_send, input logic [7:0] id, output int stalls);
        int cyc;
        int d;
        stalls = 0;
        for (int b = 0; b < n_send; b++) begin
            s_tdata  = (b == 0) ? hdr(eth, vid, id) : body(id, b);
            s_tkeep  = '1;
            s_tuser  = UW'({id, 8'(b)});
            s_tlast  = (b == n_total - 1);
            s_tvalid = 1'b1;
            cyc = 0;
            @(negedge clk);
            while (!s_tready[0] && cyc < 50) begin
                cyc++;
                stalls++;
                @(negedge clk);
            end
            if (cyc >= 50) chk("accept_timeout", DW'(1), DW'(0));
            for (int i = 0; i < 2; i++) begin
                d = dest_of(i, eth, vid);
                if (b == 0) begin
                    if (d == 3) drop_exp[i]++;
                    else begin
                        cnt_exp[i][d]++;
                        pin_exp[i]++;
                    end
                end
                if (d != 3) exp_q[i*3+d].push_back(s_tdata);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_idle();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            for (int q = 0; q < 3; q++) cnt_exp[i][q] = 0;
            drop_exp[i] = 0;
            pin_exp[i]  = 0;
        end
    endtask

    task automatic do_reset();
        go_idle();
        rstn = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        pin_base[0] = pin_cnt[0];
        pin_base[1] = pin_cnt[1];
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string name);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            chk({name, "_beats"}, DW'(got_q[k].size()), DW'(exp_q[k].size()));
            for (int j = pos[k]; j < got_q[k].size() && j < exp_q[k].size(); j++)
                chk({name, "_data"}, got_q[k][j], exp_q[k][j]);
            pos[k] = (got_q[k].size() > exp_q[k].size()) ? got_q[k].size() : exp_q[k].size();
        end
        for (int i = 0; i < 2; i++) begin
            for (int q = 0; q < 3; q++)
                chk({name, "_pkt_cnt"}, DW'(pkt_cnt[i][q]), DW'(cnt_exp[i][q]));
            chk({name, "_drop_cnt"}, DW'(drop_cnt[i]), DW'(drop_exp[i]));
            chk({name, "_pkt_in"}, DW'(pin_cnt[i] - pin_base[i]), DW'(pin_exp[i]));
        end
        $display("%s: checks=%0d failures=%0d", name, n_checks, n_fail);
    endtask

    int st, st2;
    int vbase [6];

    initial begin
        for (int k = 0; k < 6; k++) pos[k] = 0;
        pin_base[0] = 0;
        pin_base[1] = 0;
        clear_model();
        base_rdy = 3'b111;
        tog_rdy  = 1'b0;
        bp_mode  = 1'b0;
        s_tkeep  = '1;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        s_tdata  = hdr(16'h8100, 12'd0, 8'h00);
        s_tvalid = 1'b1;
        rstn     = 1'b0;

        // Reset state with a valid header presented: nothing may be forwarded or accepted.
        #12;
        chk("rst_tvalid0", DW'(m_tvalid[0][0]), DW'(0));
        chk("rst_tready", DW'(s_tready[0]), DW'(0));
        chk("rst_pkt_cnt0", DW'(pkt_cnt[0][0]), DW'(0));
        chk("rst_drop_cnt", DW'(drop_cnt[0]), DW'(0));
        chk("rst_pkt_in", DW'(pkt_in[0]), DW'(0));
        do_reset();

        // VID 0/1/2, four beats each
        send_pkt(16'h8100, 12'd0, 4, 4, 8'h10, st);
        send_pkt(16'h8100, 12'd1, 4, 4, 8'h11, st);
        send_pkt(16'h8100, 12'd2, 4, 4, 8'h12, st);
        go_idle();
        compare("vid012");

        // Untagged IPv4 goes to the default switch regardless of the VID field bits
        do_reset();
        send_pkt(16'h0800, 12'd2, 3, 3, 8'h20, st);
        go_idle();
        compare("untagged");

        // Unmapped VID: dropped by instance 0, default-switched by instance 1
        do_reset();
        for (int k = 0; k < 6; k++) vbase[k] = vcnt[k];
        send_pkt(16'h8100, 12'd7, 3, 3, 8'h30, st);
        go_idle();
        chk("drop_no_stall", DW'(st), DW'(0));
        compare("unmapped");
        for (int q = 0; q < 3; q++) chk("drop_no_tvalid", DW'(vcnt[q] - vbase[q]), DW'(0));

        // Backpressure on the selected master only
        do_reset();
        for (int k = 0; k < 6; k++) vbase[k] = vcnt[k];
        base_rdy = 3'b100;
        tog_rdy  = 1'b0;
        bp_mode  = 1'b1;
        fork
            begin
                send_pkt(16'h8100, 12'd1, 5, 5, 8'h40, st);
                go_idle();
                bp_mode = 1'b0;
            end
            begin
                while (bp_mode) begin
                    @(posedge clk);
                    #1;
                    tog_rdy = ~tog_rdy;
                end
            end
        join
        base_rdy = 3'b111;
        chk("bp_stalled", DW'(st > 0), DW'(1));
        compare("backpressure");
        chk("bp_no_tvalid_m0", DW'(vcnt[0] - vbase[0]), DW'(0));
        chk("bp_no_tvalid_m2", DW'(vcnt[2] - vbase[2]), DW'(0));

        // Back-to-back single-beat packets
        do_reset();
        send_pkt(16'h8100, 12'd2, 1, 1, 8'h50, st);
        send_pkt(16'h8100, 12'd0, 1, 1, 8'h51, st2);
        go_idle();
        chk("b2b_no_bubble", DW'(st + st2), DW'(0));
        compare("b2b");

        // Reset during beat 2 of a VID 1 packet
        do_reset();
        send_pkt(16'h8100, 12'd1, 4, 2, 8'h60, st);
        s_tdata  = body(8'h60, 2);
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_tvalid", DW'(m_tvalid[0][1]), DW'(0));
        chk("midrst_tvalid_i1", DW'(m_tvalid[1][1]), DW'(0));
        chk("midrst_pkt_cnt1", DW'(pkt_cnt[0][1]), DW'(0));
        go_idle();
        clear_model();
        @(negedge clk);
        rstn = 1'b1;
        pin_base[0] = pin_cnt[0];
        pin_base[1] = pin_cnt[1];
        @(posedge clk);
        #1;
        send_pkt(16'h8100, 12'd2, 2, 2, 8'h61, st);
        go_idle();
        compare("midreset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
